// File: rtl/microwave_run_ctrl.sv
// Cook-cycle controller: debounces start/stop buttons and sequences IDLE/RUN/PAUSED/DONE with beeper.
// Optional door interlock is compiled in when DOOR_INTERLOCK_EN is defined.
module microwave_run_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int DONE_HOLD_CYCLES = 300_000_000,
    parameter int BEEP_HALF_PERIOD = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_stop,
    input  logic door_open,
    input  logic timerEnd,
    output logic start,
    output logic idle,
    output logic paused,
    output logic done,
    output logic clear_time,
    output logic beep
);

    localparam int NUM_BTN = 2;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W  = $clog2(DONE_HOLD_CYCLES + 1);
    localparam int BEEP_W  = $clog2(BEEP_HALF_PERIOD + 1);

    localparam logic [DB_W-1:0]   DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(DONE_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [BEEP_W-1:0] BEEP_TERM = BEEP_W'(BEEP_HALF_PERIOD - 1);
    localparam logic [BEEP_W-1:0] BEEP_ONE  = BEEP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;
    logic               start_ev;
    logic               stop_ev;
    logic               door_s;

    assign btn_raw  = {btn_stop, btn_start};
    assign start_ev = press[0];
    assign stop_ev  = press[1];

    // Per-button synchroniser, debounce counter and registered rising-edge press pulse.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            stable_reg;
            logic            stable_d_reg;
            logic            press_reg;
            logic [DB_W-1:0] db_cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    stable_reg   <= 1'b0;
                    stable_d_reg <= 1'b0;
                    press_reg    <= 1'b0;
                    db_cnt_reg   <= '0;
                end else begin
                    sync1_reg    <= btn_raw[gi];
                    sync2_reg    <= sync1_reg;
                    stable_d_reg <= stable_reg;
                    press_reg    <= stable_reg & ~stable_d_reg;
                    if (sync2_reg == stable_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_TERM) begin
                        stable_reg <= sync2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_ONE;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

`ifdef DOOR_INTERLOCK_EN
    // Door switch is only synchronised: an opening must stop the magnetron without debounce delay.
    logic door_sync1_reg;
    logic door_s_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            door_sync1_reg <= 1'b0;
            door_s_reg     <= 1'b0;
        end else begin
            door_sync1_reg <= door_open;
            door_s_reg     <= door_sync1_reg;
        end
    end

    assign door_s = door_s_reg;
`else
    logic door_unused;
    assign door_unused = door_open;
    assign door_s      = 1'b0;
`endif

    state_t              state_reg;
    state_t              state_next;
    logic                clear_time_reg;
    logic                clear_time_next;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [BEEP_W-1:0]   beep_cnt_reg;
    logic                beep_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            clear_time_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            clear_time_reg <= clear_time_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        clear_time_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (stop_ev) begin
                    clear_time_next = 1'b1;
                end else if (start_ev && !timerEnd && !door_s) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (door_s) begin
                    state_next = S_PAUSED;
                end else if (timerEnd) begin
                    state_next = S_DONE;
                end else if (stop_ev) begin
                    state_next = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (stop_ev) begin
                    state_next      = S_IDLE;
                    clear_time_next = 1'b1;
                end else if (start_ev && !timerEnd && !door_s) begin
                    state_next = S_RUN;
                end
            end
            S_DONE: begin
                if (start_ev || stop_ev) begin
                    state_next = S_IDLE;
                end else if (hold_cnt_reg == HOLD_TERM) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Hold and beep timers run only while staying in DONE; any other cycle preloads them for the next entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg <= '0;
            beep_cnt_reg <= '0;
            beep_reg     <= 1'b0;
        end else if (state_reg == S_DONE && state_next == S_DONE) begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_ONE;
            if (beep_cnt_reg == BEEP_TERM) begin
                beep_cnt_reg <= '0;
                beep_reg     <= ~beep_reg;
            end else begin
                beep_cnt_reg <= beep_cnt_reg + BEEP_ONE;
            end
        end else begin
            hold_cnt_reg <= '0;
            beep_cnt_reg <= '0;
            beep_reg     <= 1'b1;
        end
    end

    always_comb begin
        idle       = (state_reg == S_IDLE);
        start      = (state_reg == S_RUN);
        paused     = (state_reg == S_PAUSED);
        done       = (state_reg == S_DONE);
        beep       = (state_reg == S_DONE) && beep_reg;
        clear_time = clear_time_reg;
    end

endmodule

// File: tb/tb_microwave_run_ctrl.sv
// Self-checking bench for microwave_run_ctrl: directed scenarios plus a randomized soak against a reference model.
`timescale 1ns/1ps
module tb_microwave_run_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int BEEP = 3;

    logic clk = 1'b0;
    logic rst, btn_start, btn_stop, door_open, timerEnd;
    logic start, idle, paused, done, clear_time, beep;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    microwave_run_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .DONE_HOLD_CYCLES(HOLD),
        .BEEP_HALF_PERIOD(BEEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .door_open (door_open),
        .timerEnd  (timerEnd),
        .start     (start),
        .idle      (idle),
        .paused    (paused),
        .done      (done),
        .clear_time(clear_time),
        .beep      (beep)
    );

    // Reference model: a button level is accepted after DB consecutive differing synced samples
    // (synced = raw delayed two edges); the FSM acts on an accepted rise two edges later.
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mstate_t;
    mstate_t m_state;
    bit      m_clear;
    int      m_dcnt;
    bit      m_raw_d1 [2];
    bit      m_raw_d2 [2];
    bit      m_stable [2];
    bit      m_rise_d1[2];
    bit      m_rise_d2[2];
    int      m_run    [2];
    bit      m_door_d1, m_door_d2;

    function automatic logic [5:0] exp_vec();
        return {m_state == M_IDLE, m_state == M_RUN, m_state == M_PAUSED, m_state == M_DONE,
                m_clear, (m_state == M_DONE) && (((m_dcnt / BEEP) % 2) == 0)};
    endfunction

    always @(posedge clk) begin : model_step
        bit raw [2];
        bit ev  [2];
        bit syn;
        bit door_s;
        raw[0] = btn_start;
        raw[1] = btn_stop;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_raw_d1[b] = 0; m_raw_d2[b] = 0; m_stable[b] = 0;
                m_rise_d1[b] = 0; m_rise_d2[b] = 0; m_run[b] = 0;
            end
            m_door_d1 = 0; m_door_d2 = 0;
            m_state = M_IDLE; m_clear = 0; m_dcnt = 0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                syn = m_raw_d2[b];
                m_raw_d2[b] = m_raw_d1[b];
                m_raw_d1[b] = raw[b];
                ev[b] = m_rise_d2[b];
                m_rise_d2[b] = m_rise_d1[b];
                m_rise_d1[b] = 0;
                if (syn != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_stable[b] = syn;
                        m_run[b] = 0;
                        m_rise_d1[b] = syn;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            door_s = 0;
`ifdef DOOR_INTERLOCK_EN
            door_s = m_door_d2;
            m_door_d2 = m_door_d1;
            m_door_d1 = door_open;
`endif
            m_clear = 0;
            case (m_state)
                M_IDLE: begin
                    if (ev[1]) m_clear = 1;
                    else if (ev[0] && !timerEnd && !door_s) m_state = M_RUN;
                end
                M_RUN: begin
                    if (door_s) m_state = M_PAUSED;
                    else if (timerEnd) begin m_state = M_DONE; m_dcnt = 0; end
                    else if (ev[1]) m_state = M_PAUSED;
                end
                M_PAUSED: begin
                    if (ev[1]) begin m_state = M_IDLE; m_clear = 1; end
                    else if (ev[0] && !timerEnd && !door_s) m_state = M_RUN;
                end
                M_DONE: begin
                    if (ev[0] || ev[1]) m_state = M_IDLE;
                    else if (m_dcnt == HOLD - 1) m_state = M_IDLE;
                    else m_dcnt++;
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Clean press: 10 cycles high then 8 low, enough to debounce both edges.
    task automatic press_btn(input int which);
        if (which == 0) btn_start = 1'b1;
        else            btn_stop  = 1'b1;
        ticks(10);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        ticks(8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(3);
        checks++;
        if ({idle, start, paused, done, clear_time, beep} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=%b", {idle, start, paused, done, clear_time, beep}, 6'b100000);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({idle, start, paused, done, clear_time, beep} !== 6'b100000) begin
            errors++;
            $display("FAIL post_reset_idle got=%b want=%b", {idle, start, paused, done, clear_time, beep}, 6'b100000);
        end
    endtask

    task automatic test_start_latency();
        int n;
        bit seen;
        n = -1;
        seen = 0;
        btn_start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) btn_start = 1'b0;
            if (start && !seen) begin
                seen = 1;
                n = i - 1;
            end
        end
        checks++;
        if (!seen || n != 7) begin
            errors++;
            $display("FAIL start_latency got=%0d want=%0d", n, 7);
        end
        checks++;
        if (idle !== 1'b0 || start !== 1'b1) begin
            errors++;
            $display("FAIL run_after_press got idle=%b start=%b want idle=0 start=1", idle, start);
        end
        checks++;
        if ({idle, start, paused, done, clear_time, beep} !== exp_vec()) begin
            errors++;
            $display("FAIL latency_model got=%b want=%b", {idle, start, paused, done, clear_time, beep}, exp_vec());
        end
    endtask

    task automatic test_glitch_pause();
        int len;
        int clr_cnt;
        int clr_at;
        bit clr_idle;
        len = $urandom_range(1, DB - 1);
        btn_stop = 1'b1;
        ticks(len);
        btn_stop = 1'b0;
        ticks(10);
        len = $urandom_range(1, DB - 1);
        btn_start = 1'b1;
        ticks(len);
        btn_start = 1'b0;
        ticks(10);
        checks++;
        if (start !== 1'b1 || paused !== 1'b0) begin
            errors++;
            $display("FAIL glitch_no_change got start=%b paused=%b want start=1 paused=0", start, paused);
        end
        press_btn(1);
        checks++;
        if (paused !== 1'b1 || start !== 1'b0) begin
            errors++;
            $display("FAIL stop_pauses got paused=%b start=%b want paused=1 start=0", paused, start);
        end
        clr_cnt = 0;
        clr_at = -1;
        clr_idle = 0;
        btn_stop = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) btn_stop = 1'b0;
            if (clear_time === 1'b1) begin
                clr_cnt++;
                clr_at = i;
                clr_idle = idle;
            end
        end
        checks++;
        if (clr_cnt != 1 || clr_at != 8 || clr_idle != 1'b1) begin
            errors++;
            $display("FAIL cancel_clear_pulse got count=%0d at=%0d idle=%b want count=1 at=8 idle=1",
                     clr_cnt, clr_at, clr_idle);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL cancel_to_idle got idle=%b want 1", idle);
        end
    endtask

    task automatic test_done();
        int n;
        bit want_beep;
        press_btn(0);
        timerEnd = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_next_cycle got=%b want=1", done);
        end
        timerEnd = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            if (i > 0) tick();
            want_beep = ((i / BEEP) % 2) == 0;
            checks++;
            if (done !== 1'b1 || beep !== want_beep) begin
                errors++;
                $display("FAIL beep_cycle%0d got done=%b beep=%b want done=1 beep=%b", i, done, beep, want_beep);
            end
        end
        tick();
        checks++;
        if (idle !== 1'b1 || beep !== 1'b0) begin
            errors++;
            $display("FAIL done_timeout got idle=%b beep=%b want idle=1 beep=0", idle, beep);
        end
        press_btn(0);
        timerEnd = 1'b1;
        tick();
        timerEnd = 1'b0;
        n = -1;
        btn_stop = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 10) btn_stop = 1'b0;
            if (idle && n < 0) n = i;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL done_ack_stop got idle_at=%0d want=%0d", n, 8);
        end
    endtask

    task automatic test_corners();
        timerEnd = 1'b1;
        press_btn(0);
        checks++;
        if (idle !== 1'b1 || start !== 1'b0) begin
            errors++;
            $display("FAIL idle_timerend_start got idle=%b start=%b want idle=1 start=0", idle, start);
        end
        timerEnd = 1'b0;
        press_btn(0);
        btn_stop = 1'b1;
        ticks(7);
        timerEnd = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || paused !== 1'b0) begin
            errors++;
            $display("FAIL run_timerend_stop got done=%b paused=%b want done=1 paused=0", done, paused);
        end
        timerEnd = 1'b0;
        btn_stop = 1'b0;
        ticks(25);
        press_btn(0);
        press_btn(1);
        checks++;
        if (paused !== 1'b1) begin
            errors++;
            $display("FAIL reach_paused got=%b want=1", paused);
        end
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        ticks(10);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        ticks(8);
        checks++;
        if (idle !== 1'b1 || start !== 1'b0) begin
            errors++;
            $display("FAIL paused_both_press got idle=%b start=%b want idle=1 start=0", idle, start);
        end
        checks++;
        if ({idle, start, paused, done, clear_time, beep} !== exp_vec()) begin
            errors++;
            $display("FAIL corners_model got=%b want=%b", {idle, start, paused, done, clear_time, beep}, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        press_btn(0);
        btn_stop = 1'b1;
        ticks(3);
        rst = 1'b1;
        btn_stop = 1'b0;
        tick();
        checks++;
        if ({idle, start, paused, done, clear_time, beep} !== 6'b100000) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%b want=%b", {idle, start, paused, done, clear_time, beep}, 6'b100000);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (idle !== 1'b1 || paused !== 1'b0 || clear_time !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_late_event got late activity after reset want none");
        end
    endtask

`ifdef DOOR_INTERLOCK_EN
    task automatic test_door();
        int n;
        press_btn(0);
        n = -1;
        door_open = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (paused && n < 0) n = i;
        end
        checks++;
        if (n < 1 || n > 3) begin
            errors++;
            $display("FAIL door_pause got=%0d want<=3", n);
        end
        press_btn(0);
        checks++;
        if (paused !== 1'b1 || start !== 1'b0) begin
            errors++;
            $display("FAIL door_blocks_start got paused=%b start=%b want paused=1 start=0", paused, start);
        end
        door_open = 1'b0;
        ticks(4);
        press_btn(0);
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL door_resume got=%b want=1", start);
        end
    endtask
`endif

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 300; seg++) begin
            len = $urandom_range(1, 12);
            btn_start = ($urandom_range(0, 3) == 0);
            btn_stop  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) timerEnd = ~timerEnd;
`ifdef DOOR_INTERLOCK_EN
            door_open = ($urandom_range(0, 7) == 0);
`endif
            rst = ($urandom_range(0, 80) == 0);
            for (int i = 0; i < len; i++) begin
                tick();
                rst = 1'b0;
                checks++;
                if ({idle, start, paused, done, clear_time, beep} !== exp_vec()) begin
                    errors++;
                    $display("FAIL random_seg%0d got=%b want=%b", seg,
                             {idle, start, paused, done, clear_time, beep}, exp_vec());
                end
            end
        end
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        timerEnd  = 1'b0;
        door_open = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        btn_start = 1'b0;
        btn_stop = 1'b0;
        door_open = 1'b0;
        timerEnd = 1'b0;
        test_reset();
        test_start_latency();
        test_glitch_pause();
        test_done();
        test_corners();
        test_reset_mid();
`ifdef DOOR_INTERLOCK_EN
        test_door();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
